// File: rtl/arb_fifo_int.sv
// arb_fifo_int: four per-lane packet FIFOs merged into one byte stream by a packet-granular arbiter.
// Winner selection is round-robin by default. Defining ARB_FIFO_INT_FIXED_PRIO_EN switches it to
// fixed priority, with lane 0 highest.
module arb_fifo_int #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_ctl,
  output logic [7:0]  out_data,
  output logic        out_ctl,
  output logic [3:0]  grant,
  output logic [3:0]  lane_rdy,
  output logic [3:0]  ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  logic       state;
  logic [1:0] cur;
  logic [1:0] win;
  logic [8:0] head [4];
  logic [3:0] pop;
  logic [3:0] pop_last;
`ifndef ARB_FIFO_INT_FIXED_PRIO_EN
  logic [1:0] last_win;
`endif
  assign pop = (state == SEND) ? grant : 4'b0000;
  genvar i;
  for (i = 0; i < 4; i++) begin : g_lane
    logic [8:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   used;
    logic [AW:0]   pkts;
    logic [AW-1:0] nxt_a;
    logic [7:0]    d;
    logic          c;
    logic          open;
    logic          hdr;
    logic          wr;
    logic          full;
    logic          close;
    logic          ovf_r;
    assign d = in_data[8*i +: 8];
    assign c = in_ctl[i];
    assign hdr = c && d != 8'h00;
    assign wr = hdr || (!c && open);
    assign close = c && open;
    assign used = wr_ptr - rd_ptr;
    assign full = used == FULL;
    assign nxt_a = rd_ptr[AW-1:0] + AW'(1);
    assign head[i] = mem[rd_ptr[AW-1:0]];
    assign pop_last[i] = pop[i] && (used == (AW+1)'(1) || mem[nxt_a][8]);
    assign lane_rdy[i] = pkts != '0;
    assign ovf[i] = ovf_r;
    // Entry storage: header and payload bytes only, writes into a full FIFO are lost
    always_ff @(posedge clk)
      if (wr && !full) mem[wr_ptr[AW-1:0]] <= {c, d};
    // Pointers, open-packet flag, complete-packet count and sticky overflow
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        pkts   <= '0;
        open   <= 1'b0;
        ovf_r  <= 1'b0;
      end else begin
        if (wr && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop[i]) rd_ptr <= rd_ptr + (AW+1)'(1);
        if (wr && full) ovf_r <= 1'b1;
        if (c) open <= hdr;
        pkts <= pkts + (AW+1)'(close) - (AW+1)'(pop_last[i]);
      end
  end
  // Pick the first lane holding a complete packet in search order
  always_comb begin
    win = 2'd0;
`ifdef ARB_FIFO_INT_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) if (lane_rdy[k]) win = 2'(k);
`else
    for (int k = 4; k >= 1; k--) if (lane_rdy[last_win + 2'(k)]) win = last_win + 2'(k);
`endif
  end
  // IDLE/SEND arbiter: lock a grant for a whole packet, stream it, then idle for at least one cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      cur      <= 2'd0;
      out_ctl  <= 1'b1;
      out_data <= 8'h00;
`ifndef ARB_FIFO_INT_FIXED_PRIO_EN
      last_win <= 2'd3;
`endif
    end else if (state == IDLE) begin
      {out_ctl, out_data} <= 9'h100;
      if (|lane_rdy) begin
        state <= SEND;
        grant <= 4'b0001 << win;
        cur   <= win;
`ifndef ARB_FIFO_INT_FIXED_PRIO_EN
        last_win <= win;
`endif
      end
    end else begin
      {out_ctl, out_data} <= head[cur];
      if (pop_last[cur]) begin
        state <= IDLE;
        grant <= 4'b0000;
      end
    end
endmodule

// File: tb/tb_arb_fifo_int.sv
// tb_arb_fifo_int: random and directed stimulus checked cycle by cycle against a queue-based packet model
module tb_arb_fifo_int;
  localparam int DEPTH = 16;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_ctl;
  logic [7:0]  out_data;
  logic        out_ctl;
  logic [3:0]  grant;
  logic [3:0]  lane_rdy;
  logic [3:0]  ovf;
  int n_chk = 0;
  int n_bad = 0;
  arb_fifo_int #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctl(in_ctl),
    .out_data(out_data), .out_ctl(out_ctl), .grant(grant), .lane_rdy(lane_rdy), .ovf(ovf)
  );
  always #5 clk = ~clk;
  logic [8:0] q [4][$];
  bit         m_open [4];
  int         m_pc [4];
  bit         m_busy;
  int         m_own;
  int         m_last;
  logic [8:0] m_out;
  logic [3:0] m_grant;
  logic [3:0] m_ovf;
  logic [3:0] prev_grant = 4'b0000;
  int         win_log [$];
  logic [8:0] out_log [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_rdy();
    logic [3:0] r;
    for (int l = 0; l < 4; l++) r[l] = m_pc[l] != 0;
    return r;
  endfunction

  task automatic model_rst();
    for (int l = 0; l < 4; l++) begin
      q[l].delete();
      m_open[l] = 0;
      m_pc[l] = 0;
    end
    m_busy = 0; m_own = 0; m_last = 3;
    m_out = 9'h100; m_grant = 4'b0000; m_ovf = 4'b0000;
  endtask

  // One clock of the reference: arbitration on pre-edge state, then lane writes
  task automatic model_step();
    int sz [4];
    logic [3:0] rdy;
    int w;
    logic [8:0] nx;
    logic [7:0] d;
    logic c;
    for (int l = 0; l < 4; l++) sz[l] = q[l].size();
    rdy = m_rdy();
    if (!m_busy) begin
      m_out = 9'h100;
      w = -1;
`ifdef ARB_FIFO_INT_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++) if (w < 0 && rdy[k]) w = k;
`else
      for (int k = 1; k <= 4; k++) if (w < 0 && rdy[(m_last + k) % 4]) w = (m_last + k) % 4;
`endif
      if (w >= 0) begin
        m_busy = 1; m_own = w; m_last = w; m_grant = 4'b0001 << w;
      end
    end else begin
      m_out = q[m_own].pop_front();
      nx = (sz[m_own] > 1) ? q[m_own][0] : 9'h100;
      if (nx[8]) begin
        m_pc[m_own]--;
        m_busy = 0;
        m_grant = 4'b0000;
      end
    end
    for (int l = 0; l < 4; l++) begin
      d = in_data[8*l +: 8];
      c = in_ctl[l];
      if (c && m_open[l]) m_pc[l]++;
      if ((c && d != 0) || (!c && m_open[l])) begin
        if (sz[l] >= DEPTH) m_ovf[l] = 1'b1;
        else q[l].push_back({c, d});
      end
      if (c) m_open[l] = d != 0;
    end
  endtask

  task automatic compare_all();
    chk("out", {out_ctl, out_data}, m_out);
    chk("grant", grant, m_grant);
    chk("lane_rdy", lane_rdy, m_rdy());
    chk("ovf", ovf, m_ovf);
    if (grant != 0 && prev_grant == 0)
      for (int k = 0; k < 4; k++) if (grant[k]) win_log.push_back(k);
    prev_grant = grant;
    if ({out_ctl, out_data} != 9'h100) out_log.push_back({out_ctl, out_data});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else model_rst();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_all();
    in_ctl = 4'hF;
    in_data = 32'h0;
  endtask

  task automatic drive(input int lane, input logic c, input logic [7:0] d);
    in_ctl[lane] = c;
    in_data[8*lane +: 8] = d;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b0;
    model_rst();
    tick();
    tick();
    chk("rst_out", {out_ctl, out_data}, 9'h100);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_rdy", lane_rdy, 4'b0000);
    chk("rst_ovf", ovf, 4'b0000);
    reset = 1'b1;
    win_log.delete();
    out_log.delete();
  endtask

  task automatic rand_drive();
    int r;
    for (int l = 0; l < 4; l++) begin
      r = $urandom_range(0, 99);
      if (q[l].size() >= DEPTH - 2) drive(l, 1'b1, 8'h00);
      else if (r < 12) drive(l, 1'b1, 8'($urandom_range(1, 255)));
      else if (r < 20) drive(l, 1'b1, 8'h00);
      else drive(l, 1'b0, 8'($urandom));
    end
  endtask

  initial begin
    logic [8:0] sp_exp [3] = '{9'h141, 9'h011, 9'h022};
    int fair_exp [8];
    bit found;
    reset = 1'b0;
    idle_all();
    do_reset();
    // single packet on lane 2
    drive(2, 1'b1, 8'h41); tick();
    drive(2, 1'b0, 8'h11); tick();
    drive(2, 1'b0, 8'h22); tick();
    drive(2, 1'b1, 8'h00); tick();
    chk("sp_rdy", lane_rdy, 4'b0100);
    idle_all();
    repeat (10) tick();
    chk("sp_win", (win_log.size() > 0) ? win_log[0] : -1, 2);
    chk("sp_len", out_log.size(), 3);
    for (int k = 0; k < 3; k++) chk("sp_byte", (k < out_log.size()) ? out_log[k] : 9'h1FF, sp_exp[k]);
    chk("sp_rdy0", lane_rdy, 4'b0000);
    // open packet on lane 1 is never granted
    do_reset();
    drive(1, 1'b1, 8'h09); tick();
    for (int k = 0; k < 3; k++) begin drive(1, 1'b0, 8'($urandom)); tick(); end
    chk("op_rdy", lane_rdy[1], 1'b0);
    chk("op_out", {out_ctl, out_data}, 9'h100);
    for (int k = 0; k < 2; k++) begin drive(1, 1'b0, 8'($urandom)); tick(); end
    chk("op_rdy_b", lane_rdy[1], 1'b0);
    chk("op_grant", grant, 4'b0000);
    drive(1, 1'b1, 8'h00); tick();
    chk("op_rdy1", lane_rdy[1], 1'b1);
    idle_all();
    repeat (12) tick();
    chk("op_len", out_log.size(), 6);
    // fairness: two complete packets per lane
    do_reset();
    for (int s = 0; s < 7; s++) begin
      for (int l = 0; l < 4; l++)
        case (s)
          0: drive(l, 1'b1, 8'h10 + 8'(l));
          3: drive(l, 1'b1, 8'h20 + 8'(l));
          6: drive(l, 1'b1, 8'h00);
          default: drive(l, 1'b0, 8'($urandom));
        endcase
      tick();
    end
    idle_all();
    repeat (70) tick();
`ifdef ARB_FIFO_INT_FIXED_PRIO_EN
    fair_exp = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    chk("fair_n", win_log.size(), 8);
    for (int k = 0; k < 8; k++) chk("fair_lane", (k < win_log.size()) ? win_log[k] : -1, fair_exp[k]);
    // overflow on lane 3
    do_reset();
    drive(3, 1'b1, 8'h33); tick();
    for (int k = 0; k < 16; k++) begin
      drive(3, 1'b0, 8'(k));
      tick();
      if (k == 14) chk("ovf_pre", ovf[3], 1'b0);
    end
    chk("ovf_set", ovf, 4'b1000);
    drive(3, 1'b1, 8'h00); tick();
    idle_all();
    repeat (30) tick();
    chk("ovf_hold", ovf[3], 1'b1);
    do_reset();
    chk("ovf_clr", ovf, 4'b0000);
    // reset during the second payload byte of a lane 2 packet
    for (int s = 0; s < 5; s++) begin
      drive(2, s == 0 || s == 4, (s == 0) ? 8'h41 : (s == 4) ? 8'h00 : 8'h11 * 8'(s));
      if (s >= 2) drive(3, s != 3, (s == 2) ? 8'h55 : (s == 3) ? 8'h66 : 8'h00);
      tick();
    end
    idle_all();
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      found = {out_ctl, out_data} == 9'h022;
    end
    chk("mr_found", found, 1'b1);
    chk("mr_pre", lane_rdy, 4'b1100);
    #2 reset = 1'b0;
    #1;
    chk("mr_out", {out_ctl, out_data}, 9'h100);
    chk("mr_grant", grant, 4'b0000);
    chk("mr_rdy", lane_rdy, 4'b0000);
    model_rst();
    tick();
    tick();
    reset = 1'b1;
    out_log.delete();
    repeat (20) tick();
    chk("mr_quiet", out_log.size(), 0);
    // random traffic against the model
    do_reset();
    repeat (1500) begin rand_drive(); tick(); end
    idle_all();
    repeat (150) tick();
    chk("rnd_drain", lane_rdy, 4'b0000);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/arb_fifo_int.md
ARB_FIFO_INT -- requirements
Module: arb_fifo_int

Interface
REQ-001 DEPTH, 16, per-lane FIFO entries (power of two, >=4).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_data  in  32  lane i byte on bits [8i+7:8i], i=0..3.
REQ-005 in_ctl  in  4  lane i control bit on bit i.
REQ-006 out_data  out  8  merged stream byte, registered.
REQ-007 out_ctl  out  1  merged stream control bit, registered.
REQ-008 grant  out  4  one-hot current owner, bit i = lane i; 0 when no owner.
REQ-009 lane_rdy  out  4  bit i = lane i holds at least one complete packet.
REQ-010 ovf  out  4  bit i = sticky overflow flag for lane i.

Function
REQ-011 Byte classes SHALL be: ctl=1 with data=0 is idle; ctl=1 with data!=0 is header; ctl=0 is payload.
REQ-012 A packet SHALL be one header plus all following ctl=0 bytes on that lane; it closes on the next ctl=1 byte on that lane.
REQ-013 Each lane SHALL store header and payload bytes as 9-bit {ctl,data} entries, one write per cycle.
REQ-014 Each lane SHALL never store idle bytes, and SHALL discard payload bytes that arrive while no packet is open.
REQ-015 A header arriving while a packet is open SHALL close that packet and open a new one.
REQ-016 Each lane SHALL keep a complete-packet counter: +1 on close, -1 when the last byte of a packet is popped (both in one cycle: unchanged); lane_rdy[i] = counter != 0.
REQ-017 The popped entry SHALL count as a packet's last byte when the entry following it is a header or the FIFO holds no further entry.
REQ-018 A write to a full lane FIFO SHALL be dropped and SHALL set ovf[i] until reset; that packet's content is then undefined.
REQ-019 A simultaneous write and pop on the same lane SHALL both take effect.
REQ-020 The arbiter SHALL have two states, IDLE and SEND.
REQ-021 In IDLE: grant=0 and out_ctl/out_data load 1/0x00; if any lane_rdy bit is set, the arbiter SHALL select a winner, register its one-hot grant and go to SEND.
REQ-022 Winner selection SHALL be round-robin: search begins at the lane after the last winner, wrapping 3->0.
REQ-023 In SEND the grant SHALL stay locked; each cycle the arbiter SHALL pop the granted lane's head entry and load it into {out_ctl,out_data}.
REQ-024 After popping the last byte (REQ-017), the arbiter SHALL return to IDLE.
REQ-025 The header SHALL appear on the outputs one cycle after grant rises, and an L-byte packet SHALL occupy L consecutive output cycles.
REQ-026 At least one idle output cycle SHALL separate consecutive packets.
REQ-027 Arbitration SHALL consider only complete packets; an open packet is never granted.

Reset
REQ-028 While reset=0, the block SHALL asynchronously: empty all FIFOs; clear counters, open flags and ovf; enter IDLE; set grant=0, out_ctl=1, out_data=0; set the round-robin pointer so lane 0 wins first.
REQ-029 Reset in mid-packet SHALL discard all buffered data; no partial packet SHALL resume.

Configuration
REQ-030 With macro ARB_FIFO_INT_FIXED_PRIO_EN defined, winner selection SHALL be fixed priority, lane 0 > 1 > 2 > 3.
REQ-031 Without ARB_FIFO_INT_FIXED_PRIO_EN, winner selection SHALL be round-robin per REQ-022; all other behaviour is identical in both builds.

Verification
REQ-032 Reset: hold reset=0 -> out_ctl=1, out_data=0x00, grant=0, lane_rdy=0, ovf=0.
REQ-033 Single packet: lane 2 gets (1,0x41),(0,0x11),(0,0x22),(1,0x00) -> lane_rdy=4'b0100, then grant=4'b0100; outputs are (1,41),(0,11),(0,22) on consecutive cycles, then (1,00); lane_rdy returns to 0.
REQ-034 Fairness: all lanes hold two complete packets each -> output order is lanes 0,1,2,3,0,1,2,3; with the macro it is 0,0,1,1,2,2,3,3.
REQ-035 Open packet: lane 1 gets header 0x09 plus three payload bytes with no closing byte -> lane_rdy[1]=0 and the outputs stay idle; a subsequent idle byte makes lane_rdy[1]=1.
REQ-036 Overflow: DEPTH+1 stored bytes to lane 3 with no pops -> ovf[3]=1 and stays 1 until reset.
REQ-037 Reset mid-SEND: drive reset=0 during the second payload byte -> outputs go to idle (1,0x00) immediately, grant=0 and all lane_rdy bits=0.
